mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_grant.sv | 62 ++++++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default constants for the instruction/data memory arbiter.
//   state_e : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   gnt_e   : which requester owns the current transaction (GNT_IF, GNT_DM)
//   *_DEF   : default parameter values used by mem_arbiter and mem_arb_grant
//   CNT_W   : width of the latency and starvation counters (covers 0..15)
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int MEM_LATENCY_DEF = 2;
    localparam int STARVE_MAX_DEF  = 4;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } gnt_e;

endpackage

// File: rtl/mem_arb_grant.sv
// ----------------------------------------------------------------------------
// mem_arb_grant
// Priority decision between the fetch and data ports, with starvation guard.
// The data port normally wins; once it has won STARVE_MAX times in a row while
// a fetch was waiting, the fetch wins the next arbitration.
//   clk, rst_n : clock, asynchronous active-low reset
//   if_valid   : fetch request pending
//   dm_valid   : load/store request pending
//   accept     : the arbiter can take a handshake this cycle
//   grant      : requester selected this cycle (meaningful when a valid is set)
// ----------------------------------------------------------------------------
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_valid,
    input  logic dm_valid,
    input  logic accept,
    output gnt_e grant
);

    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    always_comb begin
        if (if_valid && (!dm_valid || starve_cnt_q == STARVE_LIMIT)) begin
            grant = GNT_IF;
        end else begin
            grant = GNT_DM;
        end
    end

    // The counter only moves on a real handshake; a fetch that is not waiting
    // does not count as starved.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        starve_cnt_d = starve_cnt_q;
        if (accept) begin
            if (grant == GNT_IF && if_valid) begin
                starve_cnt_d = '0;
            end else if (grant == GNT_DM && dm_valid && if_valid &&
                         starve_cnt_q != STARVE_LIMIT) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks so all flops update together.
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between an instruction-fetch port and a
// load/store port. One transaction in flight: handshake (IDLE/RESP) -> ISSUE
// (one mem_en cycle) -> WAIT (MEM_LATENCY cycles) -> RESP (response pulse,
// next handshake allowed in the same cycle).
//   clk, rst_n              : clock, asynchronous active-low reset
//   if_req_*  / if_resp_*   : fetch request (valid/addr/ready) and response
//   dm_req_*  / dm_resp_*   : load/store request and response (0 data on store)
//   mem_en/we/addr/wdata/wmask : memory command, all zero when mem_en is low
//   mem_rdata               : memory read data, valid MEM_LATENCY after mem_en
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int STARVE_MAX  = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    input  logic                dm_req_valid,
    input  logic                dm_req_we,
    input  logic [ADDR_W-1:0]   dm_req_addr,
    input  logic [DATA_W-1:0]   dm_req_wdata,
    input  logic [DATA_W/8-1:0] dm_req_wmask,
    output logic                dm_req_ready,
    output logic                dm_resp_valid,
    output logic [DATA_W-1:0]   dm_resp_data,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MW = DATA_W / 8;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    gnt_e               owner_q,    owner_d;
    logic               we_q,       we_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic [DATA_W-1:0]  wdata_q,    wdata_d;
    logic [MW-1:0]      wmask_q,    wmask_d;
    logic [DATA_W-1:0]  rdata_q,    rdata_d;

    logic accept;
    logic hs;
    logic wait_last;
    gnt_e grant;

    assign accept    = (state_q == IDLE) || (state_q == RESP);
    assign hs        = accept && ((grant == GNT_IF && if_req_valid) ||
                                  (grant == GNT_DM && dm_req_valid));
    assign wait_last = (wait_cnt_q == CNT_W'(MEM_LATENCY - 1));

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_req_valid),
        .dm_valid (dm_req_valid),
        .accept   (accept),
        .grant    (grant)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            IDLE:  if (hs) state_d = ISSUE;
            ISSUE: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                if (wait_last) state_d = RESP;
                else           wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
            RESP:    state_d = hs ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction registers: latched on the handshake, read data captured in
    // the last WAIT cycle. Non-store fields are zeroed here so the memory
    // port never sees stale write data.
    always_comb begin
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        if (hs) begin
            owner_d = grant;
            if (grant == GNT_IF) begin
                we_d    = 1'b0;
                addr_d  = if_req_addr;
                wdata_d = '0;
                wmask_d = '0;
            end else begin
                we_d    = dm_req_we;
                addr_d  = dm_req_addr;
                wdata_d = dm_req_we ? dm_req_wdata : '0;
                wmask_d = dm_req_we ? dm_req_wmask : '0;
            end
        end
        if (state_q == WAIT && wait_last) begin
            rdata_d = (owner_q == GNT_DM && we_q) ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, so every output is a clean 0 during and after reset.
        if (!rst_n) begin
            owner_q <= GNT_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs. Readies are combinational on the request valids and are held
    // low while rst_n is asserted, since state alone reads IDLE then.
    always_comb begin
        if_req_ready  = rst_n && accept && if_req_valid && (grant == GNT_IF);
        dm_req_ready  = rst_n && accept && dm_req_valid && (grant == GNT_DM);
        mem_en        = (state_q == ISSUE);
        mem_we        = mem_en && we_q;
        mem_addr      = mem_en ? addr_q  : '0;
        mem_wdata     = mem_en ? wdata_q : '0;
        mem_wmask     = mem_en ? wmask_q : '0;
        if_resp_valid = (state_q == RESP) && (owner_q == GNT_IF);
        dm_resp_valid = (state_q == RESP) && (owner_q == GNT_DM);
        if_resp_data  = if_resp_valid ? rdata_q : '0;
        dm_resp_data  = dm_resp_valid ? rdata_q : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter (MEM_LATENCY=2, STARVE_MAX=4). Port drivers
// push expected memory commands and responses into queues on each handshake;
// a negedge monitor pops and compares whenever mem_en or a resp_valid is seen.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int L  = 2;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [31:0] if_req_addr, if_resp_data;
    logic        dm_req_valid, dm_req_we, dm_req_ready, dm_resp_valid;
    logic [31:0] dm_req_addr, dm_req_wdata, dm_resp_data;
    logic [3:0]  dm_req_wmask;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        mask_care;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        gnt_e        port;
        logic [31:0] data;
    } resp_exp_t;

    typedef struct {
        int   cyc;
        gnt_e port;
    } glog_t;

    req_t      if_q[$];
    req_t      dm_q[$];
    mem_exp_t  mem_exp[$];
    resp_exp_t resp_exp[$];
    glog_t     glog[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MEM_LATENCY (L),
        .STARVE_MAX  (SM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .dm_req_valid  (dm_req_valid),
        .dm_req_we     (dm_req_we),
        .dm_req_addr   (dm_req_addr),
        .dm_req_wdata  (dm_req_wdata),
        .dm_req_wmask  (dm_req_wmask),
        .dm_req_ready  (dm_req_ready),
        .dm_resp_valid (dm_resp_valid),
        .dm_resp_data  (dm_resp_data),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents seen by reads.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h0050_0093;
            32'h0000_0004: return 32'h0000_0013;
            32'h0000_0200: return 32'h1234_5678;
            default:       return {a[15:0], 16'hC0DE};
        endcase
    endfunction

    function automatic logic any_out();
        return |{if_req_ready, if_resp_valid, if_resp_data, dm_req_ready, dm_resp_valid,
                 dm_resp_data, mem_en, mem_we, mem_addr, mem_wdata, mem_wmask};
    endfunction

    // Memory: read data is valid only in cycle issue+L, garbage otherwise.
    int   iss_cyc  = 0;
    logic iss_pend = 1'b0;
    logic [31:0] iss_addr = '0;
    initial mem_rdata = 32'hBAD0_BAD0;
    always @(negedge clk) begin
        if (mem_en) begin
            iss_pend = 1'b1;
            iss_cyc  = cyc;
            iss_addr = mem_addr;
        end
        if (iss_pend && cyc == iss_cyc + L) begin
            mem_rdata = mem_model(iss_addr);
            iss_pend  = 1'b0;
        end else begin
            mem_rdata = 32'hBAD0_BAD0;
        end
    end

    // Fetch port driver
    initial begin
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        forever begin
            @(posedge clk); #1;
            if (if_q.size() > 0) begin
                if_req_valid = 1'b1;
                if_req_addr  = if_q[0].addr;
            end else begin
                if_req_valid = 1'b0;
                if_req_addr  = '0;
            end
            @(negedge clk);
            if (if_req_valid && if_req_ready) begin
                glog.push_back('{cyc, GNT_IF});
                mem_exp.push_back('{cyc + 1, 1'b0, if_req_addr, 32'h0, 4'h0, 1'b1});
                resp_exp.push_back('{cyc + 2 + L, GNT_IF, mem_model(if_req_addr)});
                void'(if_q.pop_front());
            end
        end
    end

    // Load/store port driver
    initial begin
        dm_req_valid = 1'b0;
        dm_req_we    = 1'b0;
        dm_req_addr  = '0;
        dm_req_wdata = '0;
        dm_req_wmask = '0;
        forever begin
            @(posedge clk); #1;
            if (dm_q.size() > 0) begin
                dm_req_valid = 1'b1;
                dm_req_we    = dm_q[0].we;
                dm_req_addr  = dm_q[0].addr;
                dm_req_wdata = dm_q[0].wdata;
                dm_req_wmask = dm_q[0].wmask;
            end else begin
                dm_req_valid = 1'b0;
                dm_req_we    = 1'b0;
                dm_req_addr  = '0;
                dm_req_wdata = '0;
                dm_req_wmask = '0;
            end
            @(negedge clk);
            if (dm_req_valid && dm_req_ready) begin
                glog.push_back('{cyc, GNT_DM});
                mem_exp.push_back('{cyc + 1, dm_req_we, dm_req_addr,
                                    dm_req_we ? dm_req_wdata : 32'h0,
                                    dm_req_wmask, dm_req_we});
                resp_exp.push_back('{cyc + 2 + L, GNT_DM,
                                     dm_req_we ? 32'h0 : mem_model(dm_req_addr)});
                void'(dm_q.pop_front());
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin : monitor
        mem_exp_t  me;
        resp_exp_t re;
        if (if_req_ready || dm_req_ready) begin
            check("one_ready", {31'd0, if_req_ready && dm_req_ready}, 0);
            check("ready_only_when_valid",
                  {31'd0, (if_req_ready && !if_req_valid) || (dm_req_ready && !dm_req_valid)}, 0);
        end
        if (mem_en) begin
            check("mem_cmd_expected", {31'd0, mem_exp.size() > 0}, 1);
            if (mem_exp.size() > 0) begin
                me = mem_exp.pop_front();
                check("mem_en_cycle", cyc, me.cyc);
                check("mem_we", mem_we, me.we);
                check("mem_addr", mem_addr, me.addr);
                check("mem_wdata", mem_wdata, me.wdata);
                if (me.mask_care) check("mem_wmask", mem_wmask, me.wmask);
            end
        end else begin
            check("mem_idle_zero", {31'd0, |{mem_we, mem_addr, mem_wdata, mem_wmask}}, 0);
        end
        if (if_resp_valid || dm_resp_valid) begin
            check("resp_expected", {31'd0, resp_exp.size() > 0}, 1);
            if (resp_exp.size() > 0) begin
                re = resp_exp.pop_front();
                check("resp_cycle", cyc, re.cyc);
                check("resp_port", {if_resp_valid, dm_resp_valid},
                      (re.port == GNT_IF) ? 2'b10 : 2'b01);
                check("resp_data", (re.port == GNT_IF) ? if_resp_data : dm_resp_data, re.data);
            end
        end
    end

    task automatic wait_grants(input int n);
        int k;
        k = 0;
        while (glog.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("grant_wait", {31'd0, glog.size() >= n}, 1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((if_q.size() + dm_q.size() + mem_exp.size() + resp_exp.size()) != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", k, k < 300 ? k : 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_spacing(input int b, input int n);
        for (int i = 1; i < n; i++) begin
            check("handshake_spacing", glog[b + i].cyc - glog[b + i - 1].cyc, L + 2);
        end
    endtask

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        int    b;
        int    t;
        int    rel_cyc;
        string order;
        gnt_e  exp_port;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", {31'd0, any_out()}, 0);

        // Fetch presented during reset; accepted at the first edge after release.
        if_q.push_back('{1'b0, 32'h0000_0010, 32'h0, 4'h0});
        @(negedge clk);
        check("if_ready_in_reset", {31'd0, if_req_ready}, 0);
        @(posedge clk); #2;
        rst_n   = 1'b1;
        rel_cyc = cyc;
        b = glog.size();
        wait_grants(b + 1);
        check("first_hs_cycle", glog[b].cyc, rel_cyc);
        check("first_hs_port", glog[b].port, GNT_IF);
        wait_idle();

        // Store: fields reach memory at T+1, ack with zero data at T+4.
        b = glog.size();
        dm_q.push_back('{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF});
        wait_idle();
        check("store_port", glog[b].port, GNT_DM);

        // Fetch and load together: load first, fetch at the following RESP.
        @(posedge clk); #2;
        b = glog.size();
        if_q.push_back('{1'b0, 32'h0000_0020, 32'h0, 4'h0});
        dm_q.push_back('{1'b0, 32'h0000_0200, 32'h0, 4'h0});
        wait_idle();
        check("both_first_port", glog[b].port, GNT_DM);
        check("both_second_port", glog[b + 1].port, GNT_IF);
        check_spacing(b, 2);

        // Continuous contention: starvation guard forces every fifth grant to fetch.
        @(posedge clk); #2;
        b = glog.size();
        for (int i = 0; i < 8; i++) dm_q.push_back('{1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'h0});
        for (int i = 0; i < 2; i++) if_q.push_back('{1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0});
        wait_idle();
        order = "DDDDFDDDDF";
        for (int i = 0; i < 10; i++) begin
            exp_port = (order.getc(i) == "F") ? GNT_IF : GNT_DM;
            check($sformatf("starve_order_%0d", i), glog[b + i].port, exp_port);
        end
        check_spacing(b, 10);

        // Eight back-to-back fetches: one handshake every L+2 cycles.
        @(posedge clk); #2;
        b = glog.size();
        for (int i = 0; i < 8; i++) if_q.push_back('{1'b0, 32'h80 + 32'(4 * i), 32'h0, 4'h0});
        wait_idle();
        check("b2b_count", glog.size() - b, 8);
        check_spacing(b, 8);

        // Reset in the middle of a load: outputs drop at once, no response.
        @(posedge clk); #2;
        b = glog.size();
        dm_q.push_back('{1'b0, 32'h0000_0200, 32'h0, 4'h0});
        wait_grants(b + 1);
        t = glog[b].cyc;
        do @(posedge clk); while (cyc < t + 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs_zero", {31'd0, any_out()}, 0);
        check("mid_reset_mem_cmd_done", mem_exp.size(), 0);
        resp_exp.delete();
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b1;
        b = glog.size();
        if_q.push_back('{1'b0, 32'h0000_0004, 32'h0, 4'h0});
        wait_idle();
        check("post_reset_port", glog[b].port, GNT_IF);
        repeat (4) @(negedge clk);
        check("no_leftover_expectations", mem_exp.size() + resp_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
